// File: rtl/fsk_rx_pkg.sv
// Shared FSK receive-chain definitions: word geometry, default sync pattern, hunt/data states.
package fsk_rx_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned WCNT_W = 4;
    localparam logic [WORD_W-1:0] SYNC_DEFAULT = 16'hEB90;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } sync_state_e;

endpackage

// File: rtl/fsk_frame_sync_ctrl_if.sv
// Bit-stream input and deserializer strobe bundle between the demodulator side and the frame sync controller.
interface fsk_frame_sync_ctrl_if;
    import fsk_rx_pkg::*;

    logic              enable;
    logic              bit_in;
    logic              bit_valid;
    logic              bit_out;
    logic              shift_en;
    logic              out_enable;
    logic [WCNT_W-1:0] word_cnt;
    logic              locked;
    logic              frame_done;
    logic              sync_lost;

    modport master (
        output enable, bit_in, bit_valid,
        input  bit_out, shift_en, out_enable, word_cnt, locked, frame_done, sync_lost
    );

    modport slave (
        input  enable, bit_in, bit_valid,
        output bit_out, shift_en, out_enable, word_cnt, locked, frame_done, sync_lost
    );

endinterface

// File: rtl/fsk_sync_detect.sv
// Sync-word hunter: shifts received bits in deserializer orientation and flags the bit that completes the pattern.
module fsk_sync_detect
    import fsk_rx_pkg::*;
#(
    parameter int unsigned           WIDTH     = WORD_W,
    parameter logic [WIDTH-1:0]      SYNC_WORD = SYNC_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic shift,
    input  logic bit_in,
    output logic match_c
);

    localparam int unsigned FILL_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  hunt_reg;
    logic [FILL_W-1:0] fill_cnt;
    logic [WIDTH-1:0]  hunt_next_c;

    assign hunt_next_c = {bit_in, hunt_reg[WIDTH-1:1]};

    // Fill guard keeps reset zeros from matching an all-zero pattern early.
    assign match_c = shift && (hunt_next_c == SYNC_WORD) && (fill_cnt >= FILL_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hunt_reg <= '0;
            fill_cnt <= '0;
        end else if (shift) begin
            hunt_reg <= hunt_next_c;
            if (fill_cnt != FILL_W'(WIDTH)) begin
                fill_cnt <= fill_cnt + FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/fsk_frame_sync_ctrl.sv
// Frame sync controller: hunts for the sync word, then paces the 16-bit deserializer with shift/latch strobes per frame.
module fsk_frame_sync_ctrl
    import fsk_rx_pkg::*;
#(
    parameter int unsigned      WIDTH     = WORD_W,
    parameter logic [WIDTH-1:0] SYNC_WORD = SYNC_DEFAULT,
    parameter int unsigned      NUM_WORDS = 8,
    parameter int unsigned      TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    fsk_frame_sync_ctrl_if.slave bus
);

    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = $clog2(TIMEOUT);

    sync_state_e       state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [WCNT_W-1:0] word_cnt;
    logic              latch_pend;
    logic              bit_out;
    logic              shift_en;
    logic              out_enable;
    logic              frame_done;
    logic              sync_lost;

    logic in_data_c;
    logic hunt_shift_c;
    logic match_c;
    logic timeout_c;
    logic data_bit_c;
    logic word_end_c;
    logic last_word_c;

    assign in_data_c    = (state == DATA);
    assign hunt_shift_c = bus.enable && bus.bit_valid && !in_data_c;
    assign timeout_c    = in_data_c && (gap_cnt == GAP_W'(TIMEOUT - 1));
    assign data_bit_c   = bus.enable && in_data_c && !timeout_c && bus.bit_valid;
    assign word_end_c   = data_bit_c && (bit_cnt == BIT_W'(WIDTH - 1));
    assign last_word_c  = (word_cnt == WCNT_W'(NUM_WORDS - 1));

    // Hunt history is held clear while locked so every return to HUNT starts from an empty window.
    fsk_sync_detect #(
        .WIDTH     (WIDTH),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_detect (
        .clk     (clk),
        .reset   (reset),
        .clear   (!bus.enable || in_data_c),
        .shift   (hunt_shift_c),
        .bit_in  (bus.bit_in),
        .match_c (match_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            word_cnt   <= '0;
            latch_pend <= 1'b0;
            bit_out    <= 1'b0;
            shift_en   <= 1'b0;
            out_enable <= 1'b0;
            frame_done <= 1'b0;
            sync_lost  <= 1'b0;
        end else begin
            shift_en   <= 1'b0;
            out_enable <= 1'b0;
            frame_done <= 1'b0;
            sync_lost  <= 1'b0;
            latch_pend <= 1'b0;
            if (!bus.enable) begin
                state    <= HUNT;
                bit_cnt  <= '0;
                gap_cnt  <= '0;
                word_cnt <= '0;
                bit_out  <= 1'b0;
            end else begin
                // Latch strobe trails the 16th shift by one cycle, even after the frame has closed.
                if (latch_pend) begin
                    out_enable <= 1'b1;
                    frame_done <= last_word_c;
                    word_cnt   <= last_word_c ? '0 : word_cnt + WCNT_W'(1);
                end
                if (timeout_c) begin
                    state     <= HUNT;
                    sync_lost <= 1'b1;
                    bit_cnt   <= '0;
                    gap_cnt   <= '0;
                    word_cnt  <= '0;
                end else if (data_bit_c) begin
                    bit_out  <= bus.bit_in;
                    shift_en <= 1'b1;
                    gap_cnt  <= '0;
                    bit_cnt  <= word_end_c ? '0 : bit_cnt + BIT_W'(1);
                    if (word_end_c) begin
                        latch_pend <= 1'b1;
                        if (last_word_c) begin
                            state <= HUNT;
                        end
                    end
                end else if (in_data_c) begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end else if (match_c) begin
                    state    <= DATA;
                    bit_cnt  <= '0;
                    gap_cnt  <= '0;
                    word_cnt <= '0;
                end
            end
        end
    end

    assign bus.bit_out    = bit_out;
    assign bus.shift_en   = shift_en;
    assign bus.out_enable = out_enable;
    assign bus.word_cnt   = word_cnt;
    assign bus.locked     = (state == DATA);
    assign bus.frame_done = frame_done;
    assign bus.sync_lost  = sync_lost;

endmodule

// File: tb/tb_fsk_frame_sync_ctrl.sv
// Bench for fsk_frame_sync_ctrl: three configurations share one stimulus stream and are checked against a schedule-based model.
module tb_fsk_frame_sync_ctrl;
    import fsk_rx_pkg::*;

    localparam int NDUT = 3;
    localparam int TMO  = 64;
    localparam int NW [NDUT] = '{8, 2, 8};
    localparam logic [15:0] SW [NDUT] = '{16'hEB90, 16'hEB90, 16'h0000};

    logic clk = 1'b0;
    logic reset, enable, bit_in, bit_valid;
    always #5 clk = ~clk;

    fsk_frame_sync_ctrl_if if0 ();
    fsk_frame_sync_ctrl_if if1 ();
    fsk_frame_sync_ctrl_if if2 ();

    assign if0.enable = enable;  assign if0.bit_in = bit_in;  assign if0.bit_valid = bit_valid;
    assign if1.enable = enable;  assign if1.bit_in = bit_in;  assign if1.bit_valid = bit_valid;
    assign if2.enable = enable;  assign if2.bit_in = bit_in;  assign if2.bit_valid = bit_valid;

    fsk_frame_sync_ctrl #(.NUM_WORDS(8)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    fsk_frame_sync_ctrl #(.NUM_WORDS(2)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    fsk_frame_sync_ctrl #(.SYNC_WORD(16'h0000)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

    logic [NDUT-1:0] d_sh, d_bo, d_oe, d_fd, d_sl, d_lk;
    logic [3:0]      d_wc [NDUT];
    assign d_sh = {if2.shift_en,   if1.shift_en,   if0.shift_en};
    assign d_bo = {if2.bit_out,    if1.bit_out,    if0.bit_out};
    assign d_oe = {if2.out_enable, if1.out_enable, if0.out_enable};
    assign d_fd = {if2.frame_done, if1.frame_done, if0.frame_done};
    assign d_sl = {if2.sync_lost,  if1.sync_lost,  if0.sync_lost};
    assign d_lk = {if2.locked,     if1.locked,     if0.locked};
    assign d_wc[0] = if0.word_cnt;
    assign d_wc[1] = if1.word_cnt;
    assign d_wc[2] = if2.word_cnt;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at t=%0t", name, k, act, exp, $time);
    endtask

    // Model: bits in arrival order, a 4-slot future schedule of strobes, timeout by elapsed cycles.
    longint cyc = 0;
    bit     m_data [NDUT];
    int     hcount [NDUT];
    bit     hbits  [NDUT][16];
    int     dbits  [NDUT];
    int     words  [NDUT];
    longint last   [NDUT];
    bit     s_sh [NDUT][4], s_bo [NDUT][4], s_oe [NDUT][4], s_fd [NDUT][4];
    bit     e_sh [NDUT], e_bo [NDUT], e_oe [NDUT], e_fd [NDUT], e_sl [NDUT], e_lk [NDUT];
    int     e_wc [NDUT];

    task automatic clear_sched(input int k);
        for (int s = 0; s < 4; s++) begin
            s_sh[k][s] = 1'b0; s_bo[k][s] = 1'b0; s_oe[k][s] = 1'b0; s_fd[k][s] = 1'b0;
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit v, input bit b);
        int sn;
        bit sl;
        bit hit;
        logic [15:0] sw;
        cyc++;
        sn = int'(cyc % 4);
        for (int k = 0; k < NDUT; k++) begin
            sl = 1'b0;
            sw = SW[k];
            if (r || !en) begin
                m_data[k] = 1'b0; hcount[k] = 0; dbits[k] = 0; words[k] = 0; e_wc[k] = 0;
                clear_sched(k);
            end else if (m_data[k] && (cyc - last[k]) == longint'(TMO)) begin
                m_data[k] = 1'b0; sl = 1'b1; hcount[k] = 0; dbits[k] = 0; words[k] = 0; e_wc[k] = 0;
                clear_sched(k);
            end else if (v && m_data[k]) begin
                s_sh[k][sn] = 1'b1;
                s_bo[k][sn] = b;
                dbits[k]++;
                last[k] = cyc;
                if (dbits[k] % 16 == 0) begin
                    words[k]++;
                    s_oe[k][(sn + 1) % 4] = 1'b1;
                    if (words[k] == NW[k]) begin
                        s_fd[k][(sn + 1) % 4] = 1'b1;
                        m_data[k] = 1'b0; hcount[k] = 0; dbits[k] = 0; words[k] = 0;
                    end
                end
            end else if (v) begin
                hbits[k][hcount[k] % 16] = b;
                hcount[k]++;
                if (hcount[k] >= 16) begin
                    hit = 1'b1;
                    for (int j = 0; j < 16; j++)
                        if (hbits[k][(hcount[k] - 16 + j) % 16] != sw[j]) hit = 1'b0;
                    if (hit) begin
                        m_data[k] = 1'b1; last[k] = cyc; dbits[k] = 0; words[k] = 0;
                    end
                end
            end
            e_sh[k] = s_sh[k][sn]; e_bo[k] = s_bo[k][sn];
            e_oe[k] = s_oe[k][sn]; e_fd[k] = s_fd[k][sn];
            s_sh[k][sn] = 1'b0; s_bo[k][sn] = 1'b0; s_oe[k][sn] = 1'b0; s_fd[k][sn] = 1'b0;
            e_sl[k] = sl;
            e_lk[k] = m_data[k];
            if (e_oe[k]) e_wc[k] = e_fd[k] ? 0 : e_wc[k] + 1;
        end
    endtask

    int cnt_sh [NDUT], cnt_oe [NDUT], cnt_fd [NDUT], cnt_sl [NDUT];
    logic [15:0] cap0 = '0;

    // Compare process: sample inputs at the rising edge, check every output at the falling edge.
    initial begin
        bit r_s, en_s, v_s, b_s;
        for (int k = 0; k < NDUT; k++) begin
            cnt_sh[k] = 0; cnt_oe[k] = 0; cnt_fd[k] = 0; cnt_sl[k] = 0;
        end
        forever begin
            @(posedge clk);
            r_s = reset; en_s = enable; v_s = bit_valid; b_s = bit_in;
            @(negedge clk);
            model_step(r_s, en_s, v_s, b_s);
            for (int k = 0; k < NDUT; k++) begin
                chk("shift_en",   k, 32'(d_sh[k]), 32'(e_sh[k]));
                chk("out_enable", k, 32'(d_oe[k]), 32'(e_oe[k]));
                chk("frame_done", k, 32'(d_fd[k]), 32'(e_fd[k]));
                chk("sync_lost",  k, 32'(d_sl[k]), 32'(e_sl[k]));
                chk("locked",     k, 32'(d_lk[k]), 32'(e_lk[k]));
                chk("word_cnt",   k, 32'(d_wc[k]), 32'(e_wc[k]));
                if (e_sh[k]) chk("bit_out", k, 32'(d_bo[k]), 32'(e_bo[k]));
                if (d_sh[k] === 1'b1) cnt_sh[k]++;
                if (d_oe[k] === 1'b1) cnt_oe[k]++;
                if (d_fd[k] === 1'b1) cnt_fd[k]++;
                if (d_sl[k] === 1'b1) cnt_sl[k]++;
            end
            if (d_sh[0] === 1'b1) cap0 = {d_bo[0], cap0[15:1]};
        end
    end

    task automatic step(input bit r, input bit en, input bit v, input bit b);
        reset = r; enable = en; bit_valid = v; bit_in = b;
        @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input int gap);
        step(1'b0, 1'b1, 1'b1, b);
        repeat (gap) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        for (int i = 0; i < 16; i++) send_bit(w[i], gap);
    endtask

    task automatic chk_all_zero(input string name);
        for (int k = 0; k < NDUT; k++)
            chk(name, k, 32'({d_sh[k], d_bo[k], d_oe[k], d_fd[k], d_sl[k], d_lk[k], d_wc[k]}), 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all_zero("reset_state");
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (passed %0d of %0d)", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] sync_w;
        logic [15:0] pat [8];
        int b_sh, b_oe, b_fd, b_sl, b_oe1, b_fd1;
        sync_w = 16'hEB90;
        pat = '{16'h1357, 16'h2468, 16'hFFFF, 16'h0000, 16'hA5A5, 16'h5A5A, 16'hC3C3, 16'h8001};
        reset = 1'b1; enable = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;

        // All-zero sync word: the fill guard must hold off lock until the 16th bit.
        do_reset();
        for (int i = 0; i < 15; i++) send_bit(1'b0, 2);
        chk("zero_sync_early", 2, 32'(d_lk[2]), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("zero_sync_lock", 2, 32'(d_lk[2]), 32'd1);
        chk("zero_sync_other", 0, 32'(d_lk[0]), 32'd0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Lock on EB90, then one data word 1234.
        do_reset();
        b_sh = cnt_sh[0]; b_oe = cnt_oe[0]; b_oe1 = cnt_oe[1]; b_fd1 = cnt_fd[1];
        for (int i = 0; i < 15; i++) send_bit(sync_w[i], 3);
        chk("lock_early", 0, 32'(d_lk[0]), 32'd0);
        step(1'b0, 1'b1, 1'b1, sync_w[15]);
        chk("lock_rise", 0, 32'(d_lk[0]), 32'd1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        send_word(16'h1234, 3);
        chk("word1_shifts", 0, 32'(cnt_sh[0] - b_sh), 32'd16);
        chk("word1_value", 0, 32'(cap0), 32'h1234);
        chk("word1_latch", 0, 32'(cnt_oe[0] - b_oe), 32'd1);
        chk("word1_cnt", 0, 32'(d_wc[0]), 32'd1);
        chk("word1_cnt", 1, 32'(d_wc[1]), 32'd1);

        // Second word closes the two-word frame.
        send_word(16'hA5C3, 3);
        chk("frame_latches", 1, 32'(cnt_oe[1] - b_oe1), 32'd2);
        chk("frame_done_cnt", 1, 32'(cnt_fd[1] - b_fd1), 32'd1);
        chk("frame_unlock", 1, 32'(d_lk[1]), 32'd0);
        chk("frame_wc", 1, 32'(d_wc[1]), 32'd0);
        chk("word2_cnt", 0, 32'(d_wc[0]), 32'd2);

        // Five bits then silence: exactly one timeout, no latch.
        do_reset();
        b_sl = cnt_sl[0]; b_oe = cnt_oe[0];
        send_word(sync_w, 3);
        for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 3);
        repeat (70) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("timeout_pulses", 0, 32'(cnt_sl[0] - b_sl), 32'd1);
        chk("timeout_unlock", 0, 32'(d_lk[0]), 32'd0);
        chk("timeout_no_latch", 0, 32'(cnt_oe[0] - b_oe), 32'd0);

        // Enable drops right after the 16th data bit: pending latch is cancelled.
        do_reset();
        b_oe = cnt_oe[0];
        send_word(sync_w, 3);
        for (int i = 0; i < 15; i++) send_bit(1'(i % 3 == 0), 3);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("disable_no_latch", 0, 32'(cnt_oe[0] - b_oe), 32'd0);
        chk("disable_unlock", 0, 32'(d_lk[0]), 32'd0);
        b_sh = cnt_sh[0];
        send_word(16'h0F0F, 2);
        chk("disable_no_shift", 0, 32'(cnt_sh[0] - b_sh), 32'd0);

        // Back-to-back bits for a full eight-word frame, then reset mid-word.
        do_reset();
        b_sh = cnt_sh[0]; b_oe = cnt_oe[0]; b_fd = cnt_fd[0];
        send_word(sync_w, 0);
        for (int w = 0; w < 8; w++) send_word(pat[w], 0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("b2b_shifts", 0, 32'(cnt_sh[0] - b_sh), 32'd128);
        chk("b2b_latches", 0, 32'(cnt_oe[0] - b_oe), 32'd8);
        chk("b2b_frames", 0, 32'(cnt_fd[0] - b_fd), 32'd1);
        send_word(sync_w, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        chk("midword_locked", 0, 32'(d_lk[0]), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk_all_zero("midword_reset");
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fsk_frame_sync_ctrl.md
Name: fsk_frame_sync_ctrl

Overview:
Sequencing controller for the 16-bit serial-to-parallel deserializer in the FSK receive chain. Hunts the demodulated bit stream for a sync word. Once locked:
- forwards each data bit with a shift strobe (drives the deserializer shift clock enable);
- pulses the word-latch enable (the deserializer's out_enable) after every 16 bits;
- counts words per frame and returns to hunting at end of frame or on bit-stream timeout.

Parameters:
WIDTH, 16, bits per word; also the sync-word length.
SYNC_WORD, 16'hEB90, pattern matched in hunt register orientation.
NUM_WORDS, 8, data words per frame after sync (1..16).
TIMEOUT, 64, max clk cycles between bit_valid pulses while locked.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  receiver enable; low forces hunt and suppresses all strobes.
bit_in  in  1  demodulated bit; qualified by bit_valid.
bit_valid  in  1  one-cycle strobe per received bit (one per 16 clk_16 periods upstream).
bit_out  out  1  registered copy of the data bit, driven to the deserializer serial input.
shift_en  out  1  one-cycle shift strobe, aligned with bit_out.
out_enable  out  1  one-cycle word-latch strobe to the deserializer parallel register.
word_cnt  out  4  index of the word being assembled (0..NUM_WORDS-1).
locked  out  1  high while in DATA state.
frame_done  out  1  one-cycle pulse coincident with the final out_enable of a frame.
sync_lost  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: state=HUNT; hunt_reg=0; fill_cnt=0; bit_cnt=0; word_cnt=0; gap_cnt=0. All outputs 0.
- Priority, highest first: reset, then enable=0, then timeout, then bit_valid.
- enable=0 (any state): next cycle state=HUNT and all counters are cleared. No shift_en, out_enable, frame_done or sync_lost is issued. A strobe that was already pending from the previous cycle is cancelled.
- HUNT:
  - On bit_valid: hunt_reg <= {bit_in, hunt_reg[WIDTH-1:1]} (newest bit at MSB, oldest at bit 0, same orientation as the deserializer). fill_cnt saturates at WIDTH.
  - Match condition: the updated hunt_reg == SYNC_WORD and (fill_cnt+1) >= WIDTH. This prevents matching on reset zeros.
  - On match: state=DATA, bit_cnt=0, word_cnt=0, gap_cnt=0. locked goes high the next cycle.
  - The sync bits are never forwarded: no shift_en in HUNT.
- DATA:
  - On each bit_valid (cycle N): bit_out=bit_in and shift_en=1 in cycle N+1 (latency 1). bit_cnt increments and gap_cnt clears.
  - When bit_valid arrives with bit_cnt==WIDTH-1: bit_cnt wraps to 0 and out_enable=1 in cycle N+2, one cycle after the 16th shift_en, so the latch samples the settled shift register.
  - word_cnt increments together with out_enable.
  - If word_cnt==NUM_WORDS-1 at that out_enable: frame_done=1 in the same cycle, word_cnt wraps to 0, state=HUNT, and hunt_reg/fill_cnt are cleared.
  - Without bit_valid: gap_cnt increments. When gap_cnt reaches TIMEOUT-1: state=HUNT, sync_lost=1 for one cycle, counters cleared, and no out_enable for the partial word.
  - A bit_valid arriving in the same cycle as the timeout is discarded.
- locked = (state==DATA), registered.
- A pending out_enable at the frame end still issues even though state has already returned to HUNT.
- Back-to-back bit_valid (every cycle) is supported with no drops.
- Widths: bit_cnt is clog2(WIDTH) bits; gap_cnt is clog2(TIMEOUT) bits; comparisons are unsigned.

Decomposition:
- Shared package fsk_rx_pkg holds:
  - state typedef {HUNT, DATA};
  - constants WORD_W=16 and SYNC_DEFAULT=16'hEB90, reused by the deserializer and the transmit framer.
- One sub-module, fsk_sync_detect: hunt shift register, fill counter and comparator, producing a one-cycle match pulse.
- The FSM, counters and strobe pipeline remain in the top module.

Test Plan:
- Reset then enable=1; send 16'hEB90 LSB-first, then 16 bits of 16'h1234 -> locked rises 1 cycle after the 16th sync bit; 16 shift_en pulses whose bit_out values reproduce 16'h1234; out_enable 1 cycle after the last shift_en; word_cnt 0->1.
- NUM_WORDS=2: sync, then 32 data bits -> two out_enable pulses; frame_done coincides with the second; locked=0 the following cycle; word_cnt=0.
- Right after reset, feed 16 zero bits with SYNC_WORD=16'h0000 -> lock only on the 16th bit, not before (fill guard).
- After lock, send 5 bits then no bit_valid for 64 cycles -> sync_lost pulses once; locked=0; no out_enable issued.
- Drop enable in the cycle after the 16th data bit_valid -> the pending out_enable is suppressed; state is HUNT; no strobes until a new sync.
- bit_valid held high every cycle for sync plus 8 words -> 128 shift_en, 8 out_enable, 1 frame_done; assert reset mid-word -> all outputs 0 in the next cycle.
